// File: rtl/peripheral_spram_1r1w_pipe_if.sv
// Bus bundle for the pipelined 1R1W peripheral RAM: write port, read port and clear control.
// The master drives requests; the RAM (slave) returns busy, read data and the valid pulse.
interface peripheral_spram_1r1w_pipe_if #(
  parameter int unsigned ABITS     = 10,
  parameter int unsigned DBITS     = 32,
  parameter int unsigned BYTE_BITS = 8
);
  localparam int unsigned NBE = (DBITS + BYTE_BITS - 1) / BYTE_BITS;

  logic             clr_i;
  logic             busy_o;
  logic [ABITS-1:0] waddr_i;
  logic [DBITS-1:0] din_i;
  logic             we_i;
  logic [NBE-1:0]   be_i;
  logic             re_i;
  logic [ABITS-1:0] raddr_i;
  logic [DBITS-1:0] dout_o;
  logic             dvalid_o;

  modport master (
    output clr_i, waddr_i, din_i, we_i, be_i, re_i, raddr_i,
    input  busy_o, dout_o, dvalid_o
  );

  modport slave (
    input  clr_i, waddr_i, din_i, we_i, be_i, re_i, raddr_i,
    output busy_o, dout_o, dvalid_o
  );
endinterface

// File: rtl/peripheral_spram_1r1w_pipe.sv
// 1R1W inferrable RAM with byte-lane writes, 1..3-stage read pipeline, optional
// write-first bypass and a clear engine that sweeps every word after reset or on request.
module peripheral_spram_1r1w_pipe #(
  parameter int unsigned    ABITS      = 10,
  parameter int unsigned    DBITS      = 32,
  parameter int unsigned    BYTE_BITS  = 8,
  parameter int unsigned    RD_LATENCY = 1,
  parameter int unsigned    BYPASS     = 1,
  parameter int unsigned    CLR_ON_RST = 1,
  parameter logic [DBITS-1:0] CLR_VALUE = '0
) (
  input logic                          clk_i,
  input logic                          rst_i,
  peripheral_spram_1r1w_pipe_if.slave  bus
);
  localparam int unsigned DEPTH = 2 ** ABITS;

  typedef enum logic {StIdle, StClear} state_e;

  state_e           state_q;
  logic [ABITS-1:0] cnt_q;
  logic [DBITS-1:0] mem [DEPTH];

  logic             idle;
  logic             we_acc;
  logic             re_acc;
  logic [DBITS-1:0] wmask;
  logic [DBITS-1:0] rd_word;
  logic [DBITS-1:0] rd_data;

  logic [RD_LATENCY-1:0] pv_q;
  logic [DBITS-1:0]      pd_q [RD_LATENCY];

  assign idle   = (state_q == StIdle);
  assign we_acc = bus.we_i && idle && !rst_i;
  assign re_acc = bus.re_i && idle && !rst_i;

  // Expand lane enables to a per-bit mask; the top lane may be narrower than BYTE_BITS.
  always_comb begin
    wmask = '0;
    for (int i = 0; i < DBITS; i++) begin
      wmask[i] = bus.be_i[i / BYTE_BITS];
    end
  end

  assign rd_word = mem[bus.raddr_i];

  always_comb begin
    rd_data = rd_word;
    if ((BYPASS != 0) && we_acc && (bus.waddr_i == bus.raddr_i)) begin
      rd_data = (rd_word & ~wmask) | (bus.din_i & wmask);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= (CLR_ON_RST != 0) ? StClear : StIdle;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.clr_i) begin
            state_q <= StClear;
            cnt_q   <= '0;
          end
        end
        StClear: begin
          // The last address is written on the cycle we return to idle.
          if (cnt_q == '1) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Storage is deliberately not reset; only the sweep or accepted writes touch it.
  always_ff @(posedge clk_i) begin
    if (!rst_i && (state_q == StClear)) begin
      mem[cnt_q] <= CLR_VALUE;
    end else if (we_acc) begin
      for (int i = 0; i < DBITS; i++) begin
        if (wmask[i]) begin
          mem[bus.waddr_i][i] <= bus.din_i[i];
        end
      end
    end
  end

  // Stages load only on a valid entry so the output holds across bubbles.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pv_q <= '0;
      for (int s = 0; s < RD_LATENCY; s++) begin
        pd_q[s] <= '0;
      end
    end else begin
      pv_q[0] <= re_acc;
      if (re_acc) begin
        pd_q[0] <= rd_data;
      end
      for (int s = 1; s < RD_LATENCY; s++) begin
        pv_q[s] <= pv_q[s-1];
        if (pv_q[s-1]) begin
          pd_q[s] <= pd_q[s-1];
        end
      end
    end
  end

  assign bus.busy_o   = (state_q == StClear);
  assign bus.dout_o   = pd_q[RD_LATENCY-1];
  assign bus.dvalid_o = pv_q[RD_LATENCY-1];
endmodule

// File: tb/tb_peripheral_spram_1r1w_pipe.sv
// Drives two RAM variants (32-bit/latency 3/write-first and 20-bit/latency 1/read-first)
// with shared stimulus and compares both against an array-and-schedule reference model.
module tb_peripheral_spram_1r1w_pipe;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  peripheral_spram_1r1w_pipe_if #(.ABITS(4), .DBITS(32), .BYTE_BITS(8)) ifa ();
  peripheral_spram_1r1w_pipe_if #(.ABITS(4), .DBITS(20), .BYTE_BITS(8)) ifb ();

  peripheral_spram_1r1w_pipe #(
    .ABITS(4), .DBITS(32), .BYTE_BITS(8), .RD_LATENCY(3), .BYPASS(1), .CLR_ON_RST(1),
    .CLR_VALUE(32'h0)
  ) u_dut_a (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifa)
  );

  peripheral_spram_1r1w_pipe #(
    .ABITS(4), .DBITS(20), .BYTE_BITS(8), .RD_LATENCY(1), .BYPASS(0), .CLR_ON_RST(1),
    .CLR_VALUE(20'h0)
  ) u_dut_b (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifb)
  );

  logic        clr, we, re;
  logic [3:0]  waddr, raddr, be;
  logic [31:0] din;

  assign ifa.clr_i = clr;  assign ifb.clr_i = clr;
  assign ifa.we_i  = we;   assign ifb.we_i  = we;
  assign ifa.re_i  = re;   assign ifb.re_i  = re;
  assign ifa.waddr_i = waddr;  assign ifb.waddr_i = waddr;
  assign ifa.raddr_i = raddr;  assign ifb.raddr_i = raddr;
  assign ifa.din_i = din;  assign ifb.din_i = din[19:0];
  assign ifa.be_i  = be;   assign ifb.be_i  = be[2:0];

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int busy_left = 0;

  // Reference model: word arrays plus a schedule of results keyed by due cycle.
  logic [31:0] mem   [2][16];
  logic        ev    [2][8];
  logic [31:0] ed    [2][8];
  logic [31:0] edout [2];
  int          lat   [2] = '{3, 1};
  bit          byp   [2] = '{1'b1, 1'b0};
  int          dbw   [2] = '{32, 20};

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] b, input int width);
    logic [31:0] m = '0;
    for (int i = 0; i < width; i++) m[i] = b[i / 8];
    return (old & ~m) | (d & m);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h want %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    int n = cyc;
    int slot;
    logic [31:0] word;
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        for (int s = 0; s < 8; s++) ev[d][s] = 1'b0;
        edout[d] = '0;
      end
      busy_left = 16;
    end else if (busy_left > 0) begin
      for (int d = 0; d < 2; d++) mem[d][16 - busy_left] = '0;
      busy_left--;
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (re) begin
          word = mem[d][raddr];
          if (we && (waddr == raddr) && byp[d]) word = merge(word, din, be, dbw[d]);
          slot = (n + lat[d] - 1) % 8;
          ev[d][slot] = 1'b1;
          ed[d][slot] = word;
        end
        if (we) mem[d][waddr] = merge(mem[d][waddr], din, be, dbw[d]);
      end
      if (clr) busy_left = 16;
    end
    @(posedge clk);
    #1;
    slot = n % 8;
    chk("busy_a", {31'b0, ifa.busy_o}, {31'b0, busy_left > 0});
    chk("busy_b", {31'b0, ifb.busy_o}, {31'b0, busy_left > 0});
    for (int d = 0; d < 2; d++) begin
      if (ev[d][slot]) edout[d] = ed[d][slot];
    end
    chk("dvalid_a", {31'b0, ifa.dvalid_o}, {31'b0, ev[0][slot]});
    chk("dvalid_b", {31'b0, ifb.dvalid_o}, {31'b0, ev[1][slot]});
    chk("dout_a", ifa.dout_o, edout[0]);
    chk("dout_b", {12'b0, ifb.dout_o}, edout[1]);
    ev[0][slot] = 1'b0;
    ev[1][slot] = 1'b0;
    cyc++;
  endtask

  task automatic quiet();
    rst = 0; clr = 0; we = 0; re = 0; be = '0;
  endtask

  task automatic idle(input int cycles);
    quiet();
    for (int i = 0; i < cycles; i++) step();
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] b);
    quiet(); we = 1; waddr = a; din = d; be = b;
    step();
  endtask

  task automatic do_read(input logic [3:0] a);
    quiet(); re = 1; raddr = a;
    step();
  endtask

  task automatic read_all();
    for (int a = 0; a < 16; a++) do_read(4'(a));
    idle(3);
  endtask

  logic [5:0] vseq;

  initial begin
    for (int d = 0; d < 2; d++) begin
      for (int s = 0; s < 8; s++) begin ev[d][s] = 1'b0; ed[d][s] = '0; end
      for (int a = 0; a < 16; a++) mem[d][a] = '0;
      edout[d] = '0;
    end
    waddr = '0; raddr = '0; din = '0;
    quiet();

    // Reset and power-on sweep, then every word reads back as zero.
    rst = 1; step();
    idle(16);
    read_all();

    // Partial-lane overwrite.
    do_write(4'd3, 32'hAABBCCDD, 4'b1111);
    do_write(4'd3, 32'h11223344, 4'b0101);
    do_read(4'd3);
    idle(3);
    chk("lanes_a", ifa.dout_o, 32'hAA22CC44);

    // Same-cycle read and write: write-first on A, read-first on B.
    quiet(); we = 1; re = 1; waddr = 4'd5; raddr = 4'd5; din = 32'hDEADBEEF; be = 4'b0011;
    step();
    idle(3);
    chk("bypass_a", ifa.dout_o, 32'h0000BEEF);
    chk("nobypass_b", {12'b0, ifb.dout_o}, 32'h0);

    // Read pipeline with a bubble on the latency-3 variant.
    vseq = '0;
    do_read(4'd3);              vseq[0] = ifa.dvalid_o;
    quiet(); step();            vseq[1] = ifa.dvalid_o;
    do_read(4'd5);              vseq[2] = ifa.dvalid_o;
    for (int i = 3; i < 6; i++) begin quiet(); step(); vseq[i] = ifa.dvalid_o; end
    chk("bubble_pattern", {26'b0, vseq}, 32'b010100);
    chk("bubble_last", ifa.dout_o, 32'h0000BEEF);

    // Narrow top lane on the 20-bit variant.
    do_write(4'd7, 32'h000FFFFF, 4'b0100);
    do_read(4'd7);
    idle(3);
    chk("toplane_b", {12'b0, ifb.dout_o}, 32'h000F0000);
    chk("toplane_a", ifa.dout_o, 32'h000F0000);

    // Randomised traffic including occasional clears and resets.
    for (int i = 0; i < 600; i++) begin
      we    = 1'($urandom_range(0, 1));
      re    = 1'($urandom_range(0, 1));
      waddr = 4'($urandom_range(0, 15));
      raddr = ($urandom_range(0, 2) == 0) ? waddr : 4'($urandom_range(0, 15));
      din   = $urandom();
      be    = 4'($urandom_range(0, 15));
      clr   = ($urandom_range(0, 80) == 0);
      rst   = ($urandom_range(0, 200) == 0);
      step();
    end
    idle(20);

    // Clear request with reads in flight, dropped traffic while busy, reset mid-sweep.
    do_write(4'd9, 32'h12345678, 4'b1111);
    do_read(4'd9);
    quiet(); clr = 1; re = 1; raddr = 4'd9; step();
    for (int i = 0; i < 5; i++) begin
      quiet(); we = 1; re = 1; waddr = 4'd9; raddr = 4'd9; din = 32'hFFFFFFFF; be = 4'hF;
      step();
    end
    chk("preclr_a", ifa.dout_o, 32'h12345678);
    quiet(); rst = 1; step();
    idle(16);
    chk("sweep_done", {31'b0, ifa.busy_o}, 32'h0);
    read_all();
    chk("postclr_a", ifa.dout_o, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
